// File: rtl/pdm_lockin_mixer.sv
// pdm_lockin_mixer: XOR lock-in mixer with per-channel I/Q mismatch counters over a fixed window.
// Optional macro PDM_INPUT_SYNC_EN adds a 2-flop synchronizer on ref_i, ref_q and pdm_in.
module pdm_lockin_mixer #(
    parameter int N_CH    = 4,
    parameter int WIN_LEN = 1024,
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ref_i,
    input  logic                  ref_q,
    input  logic [N_CH-1:0]       pdm_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*CNT_W-1:0] out_i,
    output logic [N_CH*CNT_W-1:0] out_q,
    output logic                  overrun
);
    // Bundle layout: {ref_q, ref_i, pdm_in}
    logic [N_CH+1:0] w_raw;
    logic [N_CH+1:0] w_mix_in;

    assign w_raw = {ref_q, ref_i, pdm_in};

`ifdef PDM_INPUT_SYNC_EN
    logic [N_CH+1:0] r_sync_p0;
    logic [N_CH+1:0] r_sync_p1;

    // Synchronizer runs freely, independent of en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= w_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_mix_in = r_sync_p1;
`else
    assign w_mix_in = w_raw;
`endif

    logic [N_CH-1:0]       w_pdm;
    logic                  w_ref_i;
    logic                  w_ref_q;
    logic [N_CH-1:0]       w_mi;
    logic [N_CH-1:0]       w_mq;
    logic [N_CH*CNT_W-1:0] w_sum_i;
    logic [N_CH*CNT_W-1:0] w_sum_q;
    logic                  w_win_end;

    logic [CNT_W-1:0]      r_cnt;
    logic [N_CH*CNT_W-1:0] r_acc_i;
    logic [N_CH*CNT_W-1:0] r_acc_q;
    logic                  r_out_valid;
    logic [N_CH*CNT_W-1:0] r_out_i;
    logic [N_CH*CNT_W-1:0] r_out_q;
    logic                  r_overrun;

    assign w_pdm     = w_mix_in[N_CH-1:0];
    assign w_ref_i   = w_mix_in[N_CH];
    assign w_ref_q   = w_mix_in[N_CH+1];
    assign w_mi      = w_pdm ^ {N_CH{w_ref_i}};
    assign w_mq      = w_pdm ^ {N_CH{w_ref_q}};
    assign w_win_end = en && (r_cnt == CNT_W'(WIN_LEN - 1));

    // Sums include the current sample so the window-end edge captures the full window
    always_comb begin
        w_sum_i = '0;
        w_sum_q = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_sum_i[c*CNT_W +: CNT_W] = r_acc_i[c*CNT_W +: CNT_W] + CNT_W'(w_mi[c]);
            w_sum_q[c*CNT_W +: CNT_W] = r_acc_q[c*CNT_W +: CNT_W] + CNT_W'(w_mq[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (en) begin
            if (w_win_end) begin
                r_cnt   <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end
        end
    end

    // A result is only dropped when the held one is still unaccepted at window end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_overrun   <= 1'b0;
        end else if (w_win_end) begin
            if (!r_out_valid || out_ready) begin
                r_out_valid <= 1'b1;
                r_out_i     <= w_sum_i;
                r_out_q     <= w_sum_q;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pdm_lockin_mixer.sv
// Testbench for pdm_lockin_mixer (N_CH=2, WIN_LEN=8): window-level model plus directed literal checks.
module tb_pdm_lockin_mixer;
    localparam int N  = 2;
    localparam int WL = 8;
    localparam int CW = $clog2(WL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          ref_i = 1'b0;
    logic          ref_q = 1'b0;
    logic [N-1:0]  pdm_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [N*CW-1:0] out_i;
    logic [N*CW-1:0] out_q;
    logic          overrun;

    int n_chk = 0;
    int n_err = 0;
    bit done  = 1'b0;

    pdm_lockin_mixer #(.N_CH(N), .WIN_LEN(WL)) dut (
        .clk(clk), .rst(rst), .en(en), .ref_i(ref_i), .ref_q(ref_q),
        .pdm_in(pdm_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: collects the mixed samples of a window, counts mismatches when it completes
    logic [N+1:0]  win_smp [WL];
    int            m_n = 0;
    logic [N+1:0]  dl0 = '0;
    logic [N+1:0]  dl1 = '0;
    bit            m_valid = 1'b0;
    bit            m_ovr = 1'b0;
    logic [N*CW-1:0] m_out_i = '0;
    logic [N*CW-1:0] m_out_q = '0;

    initial begin
        logic [N+1:0]    cur, use_smp;
        logic [N*CW-1:0] ri, rq;
        bit              fin;
        int              ci, cq;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_n = 0; dl0 = '0; dl1 = '0;
                m_valid = 1'b0; m_ovr = 1'b0; m_out_i = '0; m_out_q = '0;
            end else begin
                cur = {ref_q, ref_i, pdm_in};
`ifdef PDM_INPUT_SYNC_EN
                use_smp = dl1; dl1 = dl0; dl0 = cur;
`else
                use_smp = cur;
`endif
                fin = 1'b0;
                if (en) begin
                    win_smp[m_n] = use_smp;
                    m_n++;
                    if (m_n == WL) begin
                        fin = 1'b1;
                        m_n = 0;
                        for (int c = 0; c < N; c++) begin
                            ci = 0; cq = 0;
                            for (int k = 0; k < WL; k++) begin
                                if (win_smp[k][c] != win_smp[k][N])   ci++;
                                if (win_smp[k][c] != win_smp[k][N+1]) cq++;
                            end
                            ri[c*CW +: CW] = CW'(ci);
                            rq[c*CW +: CW] = CW'(cq);
                        end
                    end
                end
                if (fin) begin
                    if (!m_valid || out_ready) begin
                        m_valid = 1'b1; m_out_i = ri; m_out_q = rq;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !done) begin
                chk("model_valid", 32'(out_valid), 32'(m_valid));
                chk("model_overrun", 32'(overrun), 32'(m_ovr));
                if (m_valid) begin
                    chk("model_out_i", 32'(out_i), 32'(m_out_i));
                    chk("model_out_q", 32'(out_q), 32'(m_out_q));
                end
            end
        end
    end

    task automatic drv(input logic e, input logic ri, input logic rq, input logic [N-1:0] p, input logic rdy);
        @(negedge clk);
        en = e; ref_i = ri; ref_q = rq; pdm_in = p; out_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drv(1'b0, 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; ref_i = 1'b0; ref_q = 1'b0; pdm_in = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_out_i"}, 32'(out_i), 32'd0);
        chk({nm, "_out_q"}, 32'(out_q), 32'd0);
        chk({nm, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        logic b;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset("reset");

`ifdef PDM_INPUT_SYNC_EN
        // Inputs start 2 cycles ahead of en: same counts as the unsynchronized path
        do_reset();
        for (int k = 0; k < WL + 2; k++) begin
            b = k[0];
            drv(k >= 2, b, ~b, {1'b0, b}, 1'b0);
        end
        idle(1'b0);
        chk("sync_align_valid", 32'(out_valid), 32'd1);
        chk("sync_align_ch0_i", 32'(out_i[CW-1:0]), 32'd0);
        chk("sync_align_ch0_q", 32'(out_q[CW-1:0]), 32'd8);
        // en together with inputs: first two samples mix zeros
        do_reset();
        chk_reset("sync_reset");
        for (int k = 0; k < WL; k++) begin
            b = k[0];
            drv(1'b1, b, ~b, {1'b0, b}, 1'b0);
        end
        idle(1'b0);
        chk("sync_early_valid", 32'(out_valid), 32'd1);
        chk("sync_early_ch0_i", 32'(out_i[CW-1:0]), 32'd0);
        chk("sync_early_ch0_q", 32'(out_q[CW-1:0]), 32'd6);
`else
        // Reference match
        for (int k = 0; k < WL; k++) begin
            b = k[0];
            drv(1'b1, b, ~b, {1'b0, b}, 1'b0);
        end
        idle(1'b0);
        chk("refmatch_valid", 32'(out_valid), 32'd1);
        chk("refmatch_ch0_i", 32'(out_i[CW-1:0]), 32'd0);
        chk("refmatch_ch0_q", 32'(out_q[CW-1:0]), 32'd8);
        chk("refmatch_ch1_i", 32'(out_i[2*CW-1:CW]), 32'd4);
        idle(1'b1);
        idle(1'b0);
        chk("refmatch_accept_valid", 32'(out_valid), 32'd0);

        // Fixed and inverted inputs
        for (int k = 0; k < WL; k++) begin
            b = ~k[0];
            drv(1'b1, b, 1'b0, {1'b0, ~b}, 1'b0);
        end
        idle(1'b0);
        chk("fixinv_out_i", 32'(out_i), 32'h48);
        chk("fixinv_out_q", 32'(out_q), 32'h04);
        idle(1'b1);
        idle(1'b0);

        // Back-pressure across two windows
        for (int k = 0; k < 2 * WL; k++) begin
            drv(1'b1, 1'b0, 1'b1, (k < WL) ? 2'b01 : 2'b10, 1'b0);
            if (k == WL) begin
                chk("bp_first_valid", 32'(out_valid), 32'd1);
                chk("bp_first_overrun", 32'(overrun), 32'd0);
            end
        end
        idle(1'b0);
        chk("bp_held_out_i", 32'(out_i), 32'h08);
        chk("bp_held_out_q", 32'(out_q), 32'h80);
        chk("bp_overrun_set", 32'(overrun), 32'd1);
        idle(1'b1);
        idle(1'b0);
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);

        // Accept on the exact window-end cycle of window 2
        do_reset();
        chk_reset("rst2");
        for (int k = 0; k < WL; k++) drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < WL; k++) drv(1'b1, 1'b0, 1'b0, 2'b01, k == WL - 1);
        idle(1'b0);
        chk("simul_valid", 32'(out_valid), 32'd1);
        chk("simul_out_i", 32'(out_i), 32'h08);
        chk("simul_out_q", 32'(out_q), 32'h08);
        chk("simul_overrun", 32'(overrun), 32'd0);
        idle(1'b1);
        idle(1'b0);

        // Pause after 3 samples; paused cycles present ref_i=1 that must not count
        for (int k = 0; k < 3; k++) drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) drv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) drv(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        idle(1'b0);
        chk("pause_7_valid", 32'(out_valid), 32'd0);
        drv(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        idle(1'b0);
        chk("pause_8_valid", 32'(out_valid), 32'd1);
        chk("pause_out_i", 32'(out_i), 32'h33);
        chk("pause_out_q", 32'(out_q), 32'h00);
        idle(1'b1);
        idle(1'b0);

        // Reset mid-window discards the partial window
        for (int k = 0; k < 5; k++) drv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        do_reset();
        chk_reset("midrst");
        for (int k = 0; k < WL; k++) begin
            drv(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
            if (k == WL - 1) chk("midrst_7_valid", 32'(out_valid), 32'd0);
        end
        idle(1'b0);
        chk("midrst_valid", 32'(out_valid), 32'd1);
        chk("midrst_out_i", 32'(out_i), 32'h00);
        chk("midrst_out_q", 32'(out_q), 32'h88);
`endif
        idle(1'b1);
        idle(1'b0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
